jtdsp16_boot: RTL and testbench
===============================

JTDSP16_BOOT -- requirements
Module: jtdsp16_boot

Interface
REQ-001 Parameter HOLD_CYC, default 16: cycles dsp_rst stays high after the last byte is written.
REQ-002 Parameter TOUT, default 255: maximum cycles allowed for mem_ok after mem_req rises.
REQ-003 clk  input  1  system clock; all logic rises on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle request to (re)load the DSP program.
REQ-006 base  input  22  word address of image in external memory.
REQ-007 len  input  13  image length in 16-bit words, 0..4096.
REQ-008 mem_addr  output  22  external word address.
REQ-009 mem_req  output  1  external read request, level.
REQ-010 mem_ok  input  1  read data valid, one-cycle strobe.
REQ-011 mem_data  input  16  external read data.
REQ-012 prog_addr  output  13  DSP program byte address.
REQ-013 prog_data  output  8  DSP program byte.
REQ-014 prog_we  output  1  DSP program byte write strobe.
REQ-015 dsp_rst  output  1  DSP core reset, active-high.
REQ-016 busy  output  1  load in progress.
REQ-017 done  output  1  last load completed without error, level.
REQ-018 err  output  1  last load aborted on timeout, level.

Function
REQ-019 The FSM SHALL have states IDLE, FETCH, WLO, WHI, HOLD.
REQ-020 In IDLE, start=1 SHALL: latch base and len, clear word index, clear done/err, set busy and dsp_rst; next state FETCH, or HOLD if len==0.
REQ-021 In IDLE, start=0 SHALL keep all outputs stable.
REQ-022 In FETCH, mem_req SHALL be 1 and mem_addr SHALL be base+index, mod 2^22.
REQ-023 When mem_ok=1 in FETCH, the block SHALL latch mem_data, drop mem_req the next cycle, and go to WLO.
REQ-024 In WLO, prog_we SHALL be 1 for exactly one cycle, prog_addr={index,0}, prog_data=mem_data[7:0]; next state WHI.
REQ-025 In WHI, prog_we SHALL be 1 for exactly one cycle, prog_addr={index,1}, prog_data=mem_data[15:8]; next state HOLD if index==len-1, else increment index and go to FETCH.
REQ-026 Minimum throughput SHALL be 3 cycles per word when mem_ok is returned in the first FETCH cycle.
REQ-027 A timeout counter SHALL clear on FETCH entry; if TOUT cycles pass with no mem_ok, the block SHALL drop mem_req, set err, clear busy, keep dsp_rst=1, and return to IDLE.
REQ-028 mem_ok outside FETCH SHALL be ignored.
REQ-029 HOLD SHALL last exactly HOLD_CYC cycles with dsp_rst=1; it SHALL then clear dsp_rst and busy, set done, and return to IDLE.
REQ-030 start while busy SHALL be ignored.
REQ-031 The index SHALL be 13 bits; len=4096 writes bytes 0..8191 and SHALL NOT wrap before finishing.
REQ-032 prog_addr and prog_data SHALL hold their last values when prog_we=0.

Reset
REQ-033 rst SHALL force IDLE immediately, even mid-load, and set dsp_rst=1, mem_req=0, prog_we=0, busy=0, done=0, err=0, prog_addr=0, prog_data=0, mem_addr=0, index=0, and both counters=0.
REQ-034 After rst the DSP SHALL remain in reset until a load completes successfully.

Structure
REQ-035 The state encoding and the default values of HOLD_CYC and TOUT SHALL be placed in the shared jtdsp16 package.
REQ-036 The design SHALL be a single module with no sub-modules; the timeout counter and the hold counter SHALL share one 8-bit-or-wider counter.

Verification
REQ-037 Test 1: len=2, base=0x100, memory returns 0xA1B2 and 0xC3D4 with mem_ok one cycle after mem_req. Required: byte writes (0,B2), (1,A1), (2,D4), (3,C3); dsp_rst falls HOLD_CYC cycles after the last write; done=1.
REQ-038 Test 2: len=0. Required: no mem_req and no prog_we; dsp_rst falls after HOLD_CYC cycles; done=1.
REQ-039 Test 3: mem_ok never arrives. Required: err=1 exactly TOUT cycles after mem_req rises; dsp_rst stays 1; busy=0.
REQ-040 Test 4: start pulsed again mid-load. Required: no effect; byte sequence identical to Test 1.
REQ-041 Test 5: rst asserted while in WLO. Required: prog_we=0 and dsp_rst=1 with no clock edge; next start reloads from index 0.
REQ-042 Test 6: len=4096 with random 0-5 wait states per read. Required: 8192 byte writes with addresses 0..8191 in order, and byte data matches memory.

Source files
------------

// File: rtl/jtdsp16_boot_pkg.sv
// Shared definitions for the jtdsp16 program boot loader: FSM encoding,
// default timing parameters and a helper sizing the shared counter.
package jtdsp16_boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WLO   = 3'd2,
    ST_WHI   = 3'd3,
    ST_HOLD  = 3'd4
  } boot_state_e;

  localparam int HOLD_CYC_DEF = 16;
  localparam int TOUT_DEF     = 255;

  // Width of the counter shared by the read timeout and the reset hold;
  // never narrower than 8 bits, wide enough for the larger terminal count.
  function automatic int cnt_width(input int hold_cyc, input int tout);
    int top;
    top = (hold_cyc > tout) ? hold_cyc : tout;
    cnt_width = ($clog2(top + 1) > 8) ? $clog2(top + 1) : 8;
  endfunction

endpackage

// File: rtl/jtdsp16_boot.sv
// Boot loader for the jtdsp16 core: copies a program image of 16-bit words
// from external memory into the DSP program RAM as little-endian bytes,
// holding the DSP in reset until a load has completed successfully.
module jtdsp16_boot
  import jtdsp16_boot_pkg::*;
#(
  parameter int HOLD_CYC = HOLD_CYC_DEF,
  parameter int TOUT     = TOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [21:0] base,
  input  logic [12:0] len,
  output logic [21:0] mem_addr,
  output logic        mem_req,
  input  logic        mem_ok,
  input  logic [15:0] mem_data,
  output logic [12:0] prog_addr,
  output logic [7:0]  prog_data,
  output logic        prog_we,
  output logic        dsp_rst,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int            CW        = cnt_width(HOLD_CYC, TOUT);
  localparam logic [CW-1:0] TOUT_LAST = CW'(TOUT - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  boot_state_e   state_r;
  logic [21:0]   base_r;
  logic [12:0]   len_r;
  logic [12:0]   index_r;
  logic [7:0]    hi_r;      // upper byte of the fetched word, written in WHI
  logic [CW-1:0] cnt_r;     // read timeout in FETCH, reset hold in HOLD
  logic [12:0]   next_index;
  logic [21:0]   next_addr;
  logic          last_word;

  // Address of the following word and end-of-image detection.
  always_comb begin
    next_index = index_r + 13'd1;
    next_addr  = base_r + {9'd0, next_index};
    last_word  = (index_r == (len_r - 13'd1));
  end

  // Load sequencer; every output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      base_r    <= 22'd0;
      len_r     <= 13'd0;
      index_r   <= 13'd0;
      hi_r      <= 8'd0;
      cnt_r     <= '0;
      mem_addr  <= 22'd0;
      mem_req   <= 1'b0;
      prog_addr <= 13'd0;
      prog_data <= 8'd0;
      prog_we   <= 1'b0;
      dsp_rst   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      prog_we <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            base_r  <= base;
            len_r   <= len;
            index_r <= 13'd0;
            cnt_r   <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b1;
            dsp_rst <= 1'b1;
            if (len == 13'd0) begin
              state_r <= ST_HOLD;
            end else begin
              mem_addr <= base;
              mem_req  <= 1'b1;
              state_r  <= ST_FETCH;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_FETCH: begin
          if (mem_ok) begin
            hi_r      <= mem_data[15:8];
            prog_data <= mem_data[7:0];
            prog_addr <= {index_r[11:0], 1'b0};
            prog_we   <= 1'b1;
            mem_req   <= 1'b0;
            state_r   <= ST_WLO;
          end else if (cnt_r == TOUT_LAST) begin
            // Abort: the DSP stays in reset since no valid image is loaded.
            mem_req <= 1'b0;
            err     <= 1'b1;
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_WLO: begin
          prog_data <= hi_r;
          prog_addr <= {index_r[11:0], 1'b1};
          prog_we   <= 1'b1;
          state_r   <= ST_WHI;
        end
        ST_WHI: begin
          cnt_r <= '0;
          if (last_word) begin
            state_r <= ST_HOLD;
          end else begin
            index_r  <= next_index;
            mem_addr <= next_addr;
            mem_req  <= 1'b1;
            state_r  <= ST_FETCH;
          end
        end
        ST_HOLD: begin
          if (cnt_r == HOLD_LAST) begin
            dsp_rst <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          mem_req <= 1'b0;
          busy    <= 1'b0;
          dsp_rst <= 1'b1;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtdsp16_boot.sv
// Self-checking bench for jtdsp16_boot: a randomised memory responder, a
// monitor logging byte writes, and a word-to-byte reference model.
module tb_jtdsp16_boot;

  localparam int HOLD = 16;
  localparam int TO   = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [21:0] base = 22'd0;
  logic [12:0] len = 13'd0;
  logic [21:0] mem_addr;
  logic        mem_req;
  logic        mem_ok = 1'b0;
  logic [15:0] mem_data = 16'd0;
  logic [12:0] prog_addr;
  logic [7:0]  prog_data;
  logic        prog_we;
  logic        dsp_rst;
  logic        busy;
  logic        done;
  logic        err;

  jtdsp16_boot #(.HOLD_CYC(HOLD), .TOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .len(len),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_ok(mem_ok), .mem_data(mem_data),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_we(prog_we),
    .dsp_rst(dsp_rst), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // External memory image and responder controls
  logic [15:0] mem [int];
  bit          mem_en = 1'b1;
  int          max_wait = 0;
  int          wait_left = -1;

  // Monitor records
  int          cyc = 0;
  logic [12:0] wr_addr [$];
  logic [7:0]  wr_data [$];
  int          wr_cyc [$];
  int          req_rises = 0;
  int          req_rise_cyc = 0;
  int          err_rise_cyc = 0;
  int          dsp_rise_cyc = 0;
  int          dsp_fall_cyc = 0;
  bit          req_prev = 1'b0;
  bit          err_prev = 1'b0;
  bit          dsp_prev = 1'b1;

  // Reference model output
  logic [12:0] exp_addr [$];
  logic [7:0]  exp_data [$];

  function automatic logic [15:0] rd(input logic [21:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return 16'hDEAD;
  endfunction

  // Log byte writes and output edges, one sample per falling clock edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (prog_we) begin
      wr_addr.push_back(prog_addr);
      wr_data.push_back(prog_data);
      wr_cyc.push_back(cyc);
    end
    if (mem_req && !req_prev) begin
      req_rises    <= req_rises + 1;
      req_rise_cyc <= cyc;
    end
    if (err && !err_prev) err_rise_cyc <= cyc;
    if (dsp_rst && !dsp_prev) dsp_rise_cyc <= cyc;
    if (!dsp_rst && dsp_prev) dsp_fall_cyc <= cyc;
    req_prev <= mem_req;
    err_prev <= err;
    dsp_prev <= dsp_rst;
  end

  // Memory: answers a pending request after 0..max_wait idle cycles with a one-cycle mem_ok.
  initial begin : responder
    forever begin
      @(negedge clk);
      if (mem_ok) begin
        mem_ok = 1'b0;
      end else if (mem_req && mem_en) begin
        if (wait_left < 0) wait_left = $urandom_range(max_wait, 0);
        if (wait_left == 0) begin
          mem_data  = rd(mem_addr);
          mem_ok    = 1'b1;
          wait_left = -1;
        end else begin
          wait_left = wait_left - 1;
        end
      end
    end
  end

  // Overall time limit.
  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: word i of the image becomes bytes 2i (low) and 2i+1 (high).
  task automatic build_exp(input logic [21:0] b, input int n);
    logic [15:0] w;
    exp_addr.delete();
    exp_data.delete();
    for (int i = 0; i < n; i++) begin
      w = rd(b + 22'(i));
      exp_addr.push_back(13'(2 * i));
      exp_data.push_back(w[7:0]);
      exp_addr.push_back(13'(2 * i + 1));
      exp_data.push_back(w[15:8]);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  task automatic cmp_writes(input string tag);
    int f0;
    f0 = fails;
    check({tag, "_count"}, wr_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < wr_addr.size(); i++) begin
      check({tag, "_byte"}, {wr_addr[i], wr_data[i]}, {exp_addr[i], exp_data[i]});
      if (fails - f0 >= 4) break;
    end
  endtask

  task automatic pulse_start(input logic [21:0] b, input logic [12:0] l);
    base  = b;
    len   = l;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_finished"}, busy, 1'b0);
  endtask

  task automatic load(input string tag, input logic [21:0] b, input logic [12:0] l, input int budget);
    clear_log();
    pulse_start(b, l);
    check({tag, "_busy"}, busy, 1'b1);
    wait_idle(tag, budget);
  endtask

  initial begin : stimulus
    logic [21:0] b;
    logic [12:0] l;
    int          r0;

    // Reset state
    repeat (2) tick();
    check("rst_dsp_rst", dsp_rst, 1'b1);
    check("rst_outs", {mem_req, prog_we, busy, done, err}, 5'd0);
    check("rst_prog", {prog_addr, prog_data}, 21'd0);
    check("rst_mem_addr", mem_addr, 22'd0);
    rst = 1'b0;
    repeat (3) tick();
    check("idle_stable", {dsp_rst, busy, mem_req}, 3'b100);

    // Test 1: two words, response in the first FETCH cycle
    mem.delete();
    mem[32'h100] = 16'hA1B2;
    mem[32'h101] = 16'hC3D4;
    max_wait = 0;
    r0 = req_rises;
    load("t1", 22'h100, 13'd2, 200);
    exp_addr = '{13'd0, 13'd1, 13'd2, 13'd3};
    exp_data = '{8'hB2, 8'hA1, 8'hD4, 8'hC3};
    cmp_writes("t1");
    if (wr_cyc.size() == 4) begin
      check("t1_3cyc_per_word", wr_cyc[2] - wr_cyc[0], 3);
      // dsp_rst is high for HOLD full cycles following the last write cycle
      check("t1_hold", dsp_fall_cyc - wr_cyc[3], HOLD + 1);
    end
    check("t1_reqs", req_rises - r0, 2);
    check("t1_status", {done, err, dsp_rst}, 3'b100);

    // Test 2: empty image
    r0 = req_rises;
    load("t2", 22'($urandom), 13'd0, 100);
    check("t2_no_req", req_rises - r0, 0);
    check("t2_no_we", wr_addr.size(), 0);
    check("t2_hold", dsp_fall_cyc - dsp_rise_cyc, HOLD);
    check("t2_status", {done, err, dsp_rst}, 3'b100);

    // Test 3: memory never answers
    mem_en = 1'b0;
    load("t3", 22'($urandom), 13'd3, 2 * TO + 50);
    check("t3_err_time", err_rise_cyc - req_rise_cyc, TO);
    check("t3_status", {err, done, busy, dsp_rst, mem_req}, 5'b10010);
    check("t3_no_we", wr_addr.size(), 0);
    mem_en = 1'b1;
    repeat (3) tick();

    // Test 4: second start mid-load has no effect
    clear_log();
    r0 = req_rises;
    pulse_start(22'h100, 13'd2);
    tick();
    pulse_start(22'h200, 13'd7);
    wait_idle("t4", 200);
    exp_addr = '{13'd0, 13'd1, 13'd2, 13'd3};
    exp_data = '{8'hB2, 8'hA1, 8'hD4, 8'hC3};
    cmp_writes("t4");
    check("t4_reqs", req_rises - r0, 2);
    check("t4_status", {done, err, dsp_rst}, 3'b100);

    // Test 5: asynchronous reset while writing the low byte
    clear_log();
    pulse_start(22'h100, 13'd2);
    r0 = 0;
    while (!prog_we && r0 < 20) begin
      tick();
      r0++;
    end
    check("t5_reach_wlo", prog_we, 1'b1);
    rst = 1'b1;
    #1;
    check("t5_async", {prog_we, dsp_rst, busy, mem_req, done}, 5'b01000);
    check("t5_prog_clr", {prog_addr, prog_data}, 21'd0);
    rst = 1'b0;
    repeat (4) tick();
    check("t5_dsp_held", {dsp_rst, busy}, 2'b10);
    load("t5", 22'h100, 13'd2, 200);
    build_exp(22'h100, 2);
    cmp_writes("t5");
    check("t5_status", {done, dsp_rst}, 2'b10);

    // Random short images with random wait states
    for (int k = 0; k < 4; k++) begin
      mem.delete();
      b = 22'($urandom);
      l = 13'($urandom_range(9, 1));
      for (int i = 0; i < int'(l); i++) mem[int'(b + 22'(i))] = 16'($urandom);
      max_wait = $urandom_range(5, 0);
      load("rnd", b, l, 200);
      build_exp(b, int'(l));
      cmp_writes("rnd");
      check("rnd_status", {done, err, dsp_rst}, 3'b100);
    end

    // Test 6: full 4096-word image crossing the top of the address space
    mem.delete();
    b = 22'h3FF800 | 22'($urandom_range(1023, 0));
    for (int i = 0; i < 4096; i++) mem[int'(b + 22'(i))] = 16'($urandom);
    max_wait = 5;
    load("t6", b, 13'd4096, 4096 * 12);
    build_exp(b, 4096);
    cmp_writes("t6");
    if (wr_addr.size() > 0) check("t6_last_addr", wr_addr[wr_addr.size() - 1], 13'd8191);
    check("t6_status", {done, err, dsp_rst}, 3'b100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
